// File: rtl/row_readout_sequencer_pkg.sv
// Shared definitions for the column row-readout sequencer: row geometry,
// sequencer state encoding and the one-hot row helper.
package row_readout_sequencer_pkg;

   localparam int NUM_ROWS = 16;
   localparam int ROW_AW   = 4;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SCAN = 3'd1,
      ST_READ = 3'd2,
      ST_SEND = 3'd3,
      ST_DONE = 3'd4
   } seq_state_e;

   // One-hot row vector for a binary row index.
   function automatic logic [NUM_ROWS-1:0] row_onehot(input logic [ROW_AW-1:0] idx);
      logic [NUM_ROWS-1:0] one;
      one = {{(NUM_ROWS-1){1'b0}}, 1'b1};
      return one << idx;
   endfunction

endpackage

// File: rtl/row_readout_sequencer_if.sv
// Downstream word stream of the row readout sequencer (valid/ready).
interface row_readout_sequencer_if #(
   parameter int OUT_W = 25
);
   logic             OutValid;
   logic             OutReady;
   logic [OUT_W-1:0] OutData;

   modport master (output OutValid, output OutData, input OutReady);
   modport slave  (input OutValid, input OutData, output OutReady);
endinterface

// File: rtl/row_readout_sequencer_pick.sv
// Lowest-set-bit row selector: one-hot grant, binary index and any-set flag.
module row_readout_sequencer_pick
   import row_readout_sequencer_pkg::*;
(
   input  logic [NUM_ROWS-1:0] req,
   output logic [NUM_ROWS-1:0] grant,
   output logic [ROW_AW-1:0]   idx,
   output logic                any
);

   logic found_s;

   // Walk rows upward and latch the first pending one; lower rows win.
   always_comb begin
      idx     = '0;
      found_s = 1'b0;
      for (int i = 0; i < NUM_ROWS; i++) begin
         if (req[i] && !found_s) begin
            idx     = ROW_AW'(i);
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
      if (found_s) begin
         grant = row_onehot(idx);
      end else begin
         grant = '0;
      end
      any = found_s;
   end

endmodule

// File: rtl/row_readout_sequencer.sv
// Token-based readout sequencer for one 16-row pixel-region column.
// Snapshots pending hits on Start, serves them lowest row first, tags each
// word with {TrigId, RowAddr} and clears the served row after handshake.
module row_readout_sequencer
   import row_readout_sequencer_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int TRIG_W = 5,
   parameter int RD_LAT = 2
) (
   input  logic                Clk,
   input  logic                ResetB,
   input  logic                Start,
   input  logic [TRIG_W-1:0]   TrigId,
   input  logic [NUM_ROWS-1:0] HitFlag,
   input  logic [NUM_ROWS-1:0] RowMask,
   output logic [NUM_ROWS-1:0] Token,
   output logic [ROW_AW-1:0]   RowAddr,
   output logic                RdStrobe,
   input  logic [DATA_W-1:0]   RegionData,
   output logic [NUM_ROWS-1:0] ClearHit,
   output logic                Busy,
   output logic                Done,
   output logic                StartDrop,
   row_readout_sequencer_if.master out_if
);

   localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

   seq_state_e          state_q, state_d;
   logic [NUM_ROWS-1:0] snap_q, snap_d;
   logic [TRIG_W-1:0]   tag_q, tag_d;
   logic [NUM_ROWS-1:0] token_q, token_d;
   logic [ROW_AW-1:0]   row_addr_q, row_addr_d;
   logic                rd_strobe_q, rd_strobe_d;
   logic [2:0]          lat_cnt_q, lat_cnt_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                out_valid_q, out_valid_d;
   logic [NUM_ROWS-1:0] clear_q, clear_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [NUM_ROWS-1:0] pick_grant_s;
   logic [ROW_AW-1:0]   pick_idx_s;
   logic                pick_any_s;

   row_readout_sequencer_pick u_pick (
      .req   (snap_q),
      .grant (pick_grant_s),
      .idx   (pick_idx_s),
      .any   (pick_any_s)
   );

   // Next-state and next-output computation for the readout sequence.
   always_comb begin
      state_d     = state_q;
      snap_d      = snap_q;
      tag_d       = tag_q;
      token_d     = token_q;
      row_addr_d  = row_addr_q;
      rd_strobe_d = 1'b0;
      lat_cnt_d   = lat_cnt_q;
      data_d      = data_q;
      out_valid_d = out_valid_q;
      clear_d     = '0;
      busy_d      = busy_q;
      done_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               snap_d  = HitFlag & ~RowMask;
               tag_d   = TrigId;
               busy_d  = 1'b1;
               state_d = ST_SCAN;
            end else begin
               busy_d = 1'b0;
            end
         end
         ST_SCAN: begin
            if (pick_any_s) begin
               token_d     = pick_grant_s;
               row_addr_d  = pick_idx_s;
               rd_strobe_d = 1'b1;
               lat_cnt_d   = 3'd1;
               state_d     = ST_READ;
            end else begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_DONE;
            end
         end
         ST_READ: begin
            // Count 1 is the strobe cycle; capture on the RD_LAT-th cycle.
            if (lat_cnt_q == RD_LAT_C) begin
               data_d      = RegionData;
               out_valid_d = 1'b1;
               lat_cnt_d   = 3'd0;
               state_d     = ST_SEND;
            end else begin
               lat_cnt_d = lat_cnt_q + 3'd1;
            end
         end
         ST_SEND: begin
            if (out_if.OutReady) begin
               clear_d     = token_q;
               snap_d      = snap_q & ~token_q;
               token_d     = '0;
               row_addr_d  = '0;
               out_valid_d = 1'b0;
               state_d     = ST_SCAN;
            end else begin
               out_valid_d = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            token_d     = '0;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // Sequencer state and registered outputs; reset abandons any sequence.
   always_ff @(posedge Clk or negedge ResetB) begin
      if (!ResetB) begin
         state_q     <= ST_IDLE;
         snap_q      <= '0;
         tag_q       <= '0;
         token_q     <= '0;
         row_addr_q  <= '0;
         rd_strobe_q <= 1'b0;
         lat_cnt_q   <= 3'd0;
         data_q      <= '0;
         out_valid_q <= 1'b0;
         clear_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         snap_q      <= snap_d;
         tag_q       <= tag_d;
         token_q     <= token_d;
         row_addr_q  <= row_addr_d;
         rd_strobe_q <= rd_strobe_d;
         lat_cnt_q   <= lat_cnt_d;
         data_q      <= data_d;
         out_valid_q <= out_valid_d;
         clear_q     <= clear_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign Token           = token_q;
   assign RowAddr         = row_addr_q;
   assign RdStrobe        = rd_strobe_q;
   assign ClearHit        = clear_q;
   assign Busy            = busy_q;
   assign Done            = done_q;
   // A Start outside IDLE is flagged in the same cycle it arrives.
   assign StartDrop       = Start & (state_q != ST_IDLE);
   assign out_if.OutValid = out_valid_q;
   assign out_if.OutData  = {tag_q, row_addr_q, data_q};

endmodule

// File: tb/tb_row_readout_sequencer.sv
// Self-checking bench for row_readout_sequencer: timeline reference model,
// pixel/region responders, directed scenarios and randomized sequences.
module tb_row_readout_sequencer;

   localparam int DATA_W = 16;
   localparam int TRIG_W = 5;
   localparam int RD_LAT = 2;
   localparam int OUT_W  = TRIG_W + 4 + DATA_W;

   logic              Clk = 1'b0;
   logic              ResetB;
   logic              Start;
   logic [TRIG_W-1:0] TrigId;
   logic [15:0]       HitFlag, RowMask, Token, ClearHit;
   logic [3:0]        RowAddr;
   logic              RdStrobe, Busy, Done, StartDrop;
   logic [DATA_W-1:0] RegionData;

   row_readout_sequencer_if #(.OUT_W(OUT_W)) out_if ();

   row_readout_sequencer #(.DATA_W(DATA_W), .TRIG_W(TRIG_W), .RD_LAT(RD_LAT)) dut (
      .Clk(Clk), .ResetB(ResetB), .Start(Start), .TrigId(TrigId),
      .HitFlag(HitFlag), .RowMask(RowMask), .Token(Token), .RowAddr(RowAddr),
      .RdStrobe(RdStrobe), .RegionData(RegionData), .ClearHit(ClearHit),
      .Busy(Busy), .Done(Done), .StartDrop(StartDrop), .out_if(out_if)
   );

   always #5 Clk = ~Clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   // reference model: absolute cycle numbers of the expected events
   bit                seq_on;
   int                t_accept, t_grant, t_done, t_clear, clr_row;
   int                rows[$];
   logic [TRIG_W-1:0] m_tag;

   // environment: region memory, pixel hit flags, strobe age
   logic [DATA_W-1:0] mem[16];
   logic [15:0]       hits;
   int                age;

   // stimulus knobs
   bit                start_i, ready_i;
   logic [TRIG_W-1:0] trig_i;
   logic [15:0]       mask_i;

   // observations for the hand-computed checks
   int                obs_rows[$];
   logic [TRIG_W-1:0] obs_tags[$];
   logic [15:0]       obs_clr[$];
   int                obs_done_cyc, busy_cnt;

   int                eq[$];
   logic [15:0]       cq[$];
   logic [OUT_W-1:0]  held;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endfunction

   task automatic model_reset();
      seq_on  = 1'b0;
      t_grant = -1;
      t_done  = -1;
      t_clear = -1;
      rows.delete();
      age = 100;
   endtask

   task automatic clear_obs();
      obs_rows.delete();
      obs_tags.delete();
      obs_clr.delete();
      obs_done_cyc = -1;
      busy_cnt = 0;
   endtask

   task automatic check_rows(input string tname, input int exp_q[$]);
      check({tname, "_row_count"}, obs_rows.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_rows.size(); i++)
         check({tname, "_row_order"}, obs_rows[i], exp_q[i]);
   endtask

   // One clock cycle: compare outputs, respond as environment, drive inputs,
   // then advance the reference model across the coming rising edge.
   task automatic step();
      int          n, e_row, cur;
      bit          granted, e_val;
      logic [15:0] e_tok, e_clr, snap;
      @(negedge Clk);
      n       = cyc;
      granted = (t_grant >= 0) && (n >= t_grant);
      e_row   = granted ? rows[0] : 0;
      e_tok   = granted ? (16'd1 << e_row) : 16'd0;
      e_val   = granted && (n >= t_grant + RD_LAT);
      e_clr   = (n == t_clear) ? (16'd1 << clr_row) : 16'd0;
      check("token", Token, e_tok);
      check("token_onehot0", $onehot0(Token), 1);
      check("rd_strobe", RdStrobe, granted && (n == t_grant));
      check("out_valid", out_if.OutValid, e_val);
      check("clear_hit", ClearHit, e_clr);
      check("done", Done, n == t_done);
      check("busy", Busy, seq_on && (n > t_accept) && (n != t_done));
      if (granted) check("row_addr", RowAddr, e_row);
      if (e_val) check("out_data", out_if.OutData, {m_tag, 4'(e_row), mem[e_row]});
      // environment reactions
      if (ClearHit != 16'd0) obs_clr.push_back(ClearHit);
      if (Done) obs_done_cyc = n;
      if (Busy) busy_cnt++;
      hits = hits & ~ClearHit;
      cur = 0;
      for (int i = 0; i < 16; i++) if (Token[i]) cur = i;
      if (RdStrobe) age = 0;
      else if (age < 100) age++;
      RegionData = (age == RD_LAT - 1) ? mem[cur] : ~mem[cur];
      Start   = start_i;
      TrigId  = trig_i;
      RowMask = mask_i;
      HitFlag = hits;
      out_if.OutReady = ready_i;
      #1;
      check("start_drop", StartDrop, start_i && seq_on && (n > t_accept));
      if (out_if.OutValid && ready_i) begin
         obs_rows.push_back(int'(out_if.OutData[DATA_W +: 4]));
         obs_tags.push_back(out_if.OutData[DATA_W+4 +: TRIG_W]);
      end
      // model transitions
      if (start_i && !seq_on) begin
         seq_on   = 1'b1;
         t_accept = n;
         m_tag    = trig_i;
         snap     = hits & ~mask_i;
         rows.delete();
         for (int i = 0; i < 16; i++) if (snap[i]) rows.push_back(i);
         if (rows.size() > 0) t_grant = n + 2;
         else t_done = n + 2;
      end
      if (e_val && ready_i) begin
         clr_row = rows.pop_front();
         t_clear = n + 1;
         if (rows.size() > 0) t_grant = n + 2;
         else begin
            t_grant = -1;
            t_done  = n + 2;
         end
      end
      if (n == t_done) begin
         seq_on = 1'b0;
         t_done = -1;
      end
      cyc++;
      start_i = 1'b0;
   endtask

   task automatic run_until_done(input int budget, input bit rnd);
      int k = 0;
      while (obs_done_cyc < 0 && k < budget) begin
         if (rnd) begin
            ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
               start_i = 1'b1;
               trig_i  = TRIG_W'($urandom);
            end
            if ($urandom_range(0, 7) == 0) hits = hits | (16'd1 << $urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) mask_i = 16'($urandom) & 16'($urandom);
         end
         step();
         k++;
      end
      check("done_within_budget", obs_done_cyc >= 0, 1);
   endtask

   task automatic launch(input logic [15:0] h, input logic [15:0] m, input logic [TRIG_W-1:0] t);
      clear_obs();
      hits    = h;
      mask_i  = m;
      trig_i  = t;
      start_i = 1'b1;
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      for (int i = 0; i < 16; i++) mem[i] = DATA_W'($urandom);
      ResetB = 1'b0; Start = 1'b0; TrigId = '0; HitFlag = '0; RowMask = '0;
      RegionData = '0; out_if.OutReady = 1'b0;
      start_i = 1'b0; ready_i = 1'b1; trig_i = '0; mask_i = '0; hits = '0;
      model_reset();
      clear_obs();
      repeat (3) step();
      ResetB = 1'b1;
      repeat (2) step();

      // four rows across the column, downstream always ready
      t0 = cyc;
      launch(16'h8421, 16'h0000, 5'h0A);
      run_until_done(200, 1'b0);
      eq = {0, 5, 10, 15};
      check_rows("t1", eq);
      cq = {16'h0001, 16'h0020, 16'h0400, 16'h8000};
      check("t1_clear_count", obs_clr.size(), 4);
      for (int i = 0; i < 4 && i < obs_clr.size(); i++) check("t1_clear_value", obs_clr[i], cq[i]);
      foreach (obs_tags[i]) check("t1_tag", obs_tags[i], 5'h0A);
      check("t1_done_latency", obs_done_cyc - t0, 18);
      repeat (2) step();

      // masked rows are never granted nor cleared
      launch(16'h00FF, 16'h00F0, 5'h02);
      run_until_done(200, 1'b0);
      eq = {0, 1, 2, 3};
      check_rows("t2", eq);
      foreach (obs_clr[i]) check("t2_masked_clear", obs_clr[i] & 16'h00F0, 0);
      mask_i = 16'h0000;
      step();

      // empty snapshot
      t0 = cyc;
      launch(16'h0000, 16'h0000, 5'h04);
      run_until_done(20, 1'b0);
      check("t3_done_latency", obs_done_cyc - t0, 2);
      check("t3_busy_cycles", busy_cnt, 1);
      check("t3_no_words", obs_rows.size(), 0);
      step();

      // downstream stall on the first word
      ready_i = 1'b0;
      launch(16'h0003, 16'h0000, 5'h11);
      for (int k = 0; k < 50 && !out_if.OutValid; k++) step();
      check("t4_valid_seen", out_if.OutValid, 1);
      held = out_if.OutData;
      check("t4_first_row", held[DATA_W +: 4], 0);
      for (int k = 0; k < 9; k++) begin
         step();
         check("t4_valid_held", out_if.OutValid, 1);
         check("t4_data_held", out_if.OutData, held);
      end
      check("t4_no_clear_while_stalled", obs_clr.size(), 0);
      ready_i = 1'b1;
      run_until_done(200, 1'b0);
      eq = {0, 1};
      check_rows("t4", eq);

      // Start while busy is dropped; late hit is not served
      launch(16'h0104, 16'h0000, 5'h03);
      repeat (3) step();
      hits    = hits | 16'h1000;
      start_i = 1'b1;
      trig_i  = 5'h1F;
      step();
      check("t5_start_drop", StartDrop, 1);
      run_until_done(200, 1'b0);
      eq = {2, 8};
      check_rows("t5", eq);
      foreach (obs_tags[i]) check("t5_tag", obs_tags[i], 5'h03);
      hits = 16'h0000;
      step();

      // reset while the row-3 word waits downstream
      ready_i = 1'b0;
      launch(16'h0018, 16'h0000, 5'h07);
      for (int k = 0; k < 50 && !out_if.OutValid; k++) step();
      check("t6_row3_pending", out_if.OutData[DATA_W +: 4], 3);
      #2 ResetB = 1'b0;
      #1;
      check("rst_token", Token, 0);
      check("rst_row_addr", RowAddr, 0);
      check("rst_rd_strobe", RdStrobe, 0);
      check("rst_out_valid", out_if.OutValid, 0);
      check("rst_out_data", out_if.OutData, 0);
      check("rst_clear_hit", ClearHit, 0);
      check("rst_busy", Busy, 0);
      check("rst_done", Done, 0);
      model_reset();
      repeat (2) step();
      ResetB = 1'b1;
      check("t6_hit3_kept", hits[3], 1);
      ready_i = 1'b1;
      launch(hits, 16'h0000, 5'h08);
      run_until_done(200, 1'b0);
      eq = {3, 4};
      check_rows("t6", eq);

      // randomized sequences
      for (int s = 0; s < 30; s++) begin
         launch(16'($urandom), 16'($urandom) & 16'($urandom), TRIG_W'($urandom));
         run_until_done(600, 1'b1);
         repeat ($urandom_range(0, 2)) step();
      end
      repeat (4) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
